dm_port_arbiter: RTL

//  Shares the single-port data memory (IP core, 1-cycle sync read) between the MEM stage and a
//  DMA/loader requester. Pipeline has priority; a starvation counter forces one DMA slot after

---
 rtl/dm_port_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Single-port data memory arbiter: MEM stage has priority, DMA gets a forced slot
// after STARVE_LIMIT consecutive denials. DMA read data returns one cycle after grant.
//
// state   | meaning
// PL_PRI  | pipeline wins any conflict; starvation counter tracks DMA denials
// DMA_PRI | one forced DMA slot; pipeline stalled if it also requests
module dm_port_arbiter #(
    parameter int DW           = 8,
    parameter int AW           = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pl_en,
    input  logic          pl_we,
    input  logic [AW-1:0] pl_addr,
    input  logic [DW-1:0] pl_wdata,
    output logic          pl_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_ena,
    output logic          mem_wea,
    output logic [AW-1:0] mem_addra,
    output logic [DW-1:0] mem_dina,
    input  logic [DW-1:0] mem_douta
);

    typedef enum logic {
        PL_PRI  = 1'b0,
        DMA_PRI = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic       rd_owner_q;
    logic       dma_own, pl_own;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PL_PRI;
            starve_cnt <= '0;
            rd_owner_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            rd_owner_q <= dma_own & ~dma_we;
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        dma_own        = 1'b0;
        pl_own         = 1'b0;
        case (state)
            PL_PRI: begin
                if (pl_en) begin
                    pl_own = 1'b1;
                    if (dma_req && (starve_cnt == LIMIT_M1)) begin
                        state_nxt = DMA_PRI;
                    end
                end else if (dma_req) begin
                    dma_own = 1'b1;
                end
            end
            DMA_PRI: begin
                state_nxt = PL_PRI;
                if (dma_req) begin
                    dma_own = 1'b1;
                end else begin
                    pl_own = pl_en;
                end
            end
            default: state_nxt = PL_PRI;
        endcase
        // Saturating count of consecutive denials; any grant or idle cycle restarts it.
        if (!dma_req || dma_own) begin
            starve_cnt_nxt = '0;
        end else if (starve_cnt != 4'hF) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    always_comb begin
        mem_ena   = 1'b0;
        mem_wea   = 1'b0;
        mem_addra = '0;
        mem_dina  = '0;
        if (dma_own) begin
            mem_ena   = 1'b1;
            mem_wea   = dma_we;
            mem_addra = dma_addr;
            mem_dina  = dma_wdata;
        end else if (pl_own) begin
            mem_ena   = 1'b1;
            mem_wea   = pl_we;
            mem_addra = pl_addr;
            mem_dina  = pl_wdata;
        end
    end

    assign dma_gnt    = dma_own;
    assign pl_stall   = pl_en & dma_own;
    assign dma_rvalid = rd_owner_q;
    assign dma_rdata  = rd_owner_q ? mem_douta : '0;

endmodule
